// File: rtl/axi_master_mem_bridge.sv
// axi_master_mem_bridge: memory-port (req/gnt/r_valid) to AXI4 master bridge.
// One single-beat AXI4 burst per granted access, one access outstanding.
// Optional feature macro MEM2AXI_ADDR_CHECK_EN: when defined, requests outside
// [ADDR_ST, ADDR_END) are answered locally with an error and no AXI traffic.
// Handshake rule: a transfer happens on a rising clk edge where valid && ready;
// a valid never depends combinationally on its ready, and its payload stays
// stable while valid is high.
module axi_master_mem_bridge #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 10,
  parameter int AXI_ID         = 0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_ST  = 'h0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_END = 'h400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_add_i,
  input  logic                        data_wen_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] data_be_i,
  output logic                        data_gnt_o,
  output logic                        data_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_r_rdata_o,
  output logic                        err_o,
  output logic [AXI_ID_WIDTH-1:0]     awid,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  output logic [3:0]                  awqos,
  output logic [3:0]                  awregion,
  output logic [AXI_USER_WIDTH-1:0]   awuser,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_ID_WIDTH-1:0]     wid,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic [AXI_USER_WIDTH-1:0]   wuser,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [AXI_ID_WIDTH-1:0]     bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  output logic [AXI_ID_WIDTH-1:0]     arid,
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic [3:0]                  arqos,
  output logic [3:0]                  arregion,
  output logic [AXI_USER_WIDTH-1:0]   aruser,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [AXI_ID_WIDTH-1:0]     rid,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
    ~((AXI_ADDR_WIDTH'(1) << OFF) - AXI_ADDR_WIDTH'(1));
  localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA = AXI_DATA_WIDTH'(32'hDEAD_BEEF);

  state_t                      state;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] be_q;
  logic                        addr_ok;
  logic                        unused_ok;

  // Window check on the raw request address; always in range when the check is off.
`ifdef MEM2AXI_ADDR_CHECK_EN
  assign addr_ok = (data_add_i >= ADDR_ST) && (data_add_i < ADDR_END);
`else
  assign addr_ok = 1'b1;
`endif

  // Response IDs and rlast carry nothing useful for a single-beat, single-ID master.
  assign unused_ok = ^{bid, rid, rlast, ADDR_ST, ADDR_END};

  // Grant is only possible while idle, so a new access can overlap the previous completion pulse.
  assign data_gnt_o = (state == IDLE) && data_req_i;
  assign dbg_state  = state;

  // Fixed AXI attributes: single beat, full-width, INCR, no user/qos/cache hints.
  assign awid     = AXI_ID_WIDTH'(AXI_ID);
  assign awaddr   = addr_q;
  assign awlen    = 8'd0;
  assign awsize   = 3'(OFF);
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign awqos    = 4'd0;
  assign awregion = 4'd0;
  assign awuser   = '0;
  assign wid      = AXI_ID_WIDTH'(AXI_ID);
  assign wdata    = wdata_q;
  assign wstrb    = be_q;
  assign wlast    = 1'b1;
  assign wuser    = '0;
  assign arid     = AXI_ID_WIDTH'(AXI_ID);
  assign araddr   = addr_q;
  assign arlen    = 8'd0;
  assign arsize   = 3'(OFF);
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arqos    = 4'd0;
  assign arregion = 4'd0;
  assign aruser   = '0;

  // Access FSM with registered valids/readies, completion pulse, read data and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      data_r_valid_o <= 1'b0;
      data_r_rdata_o <= '0;
      err_o          <= 1'b0;
    end else begin
      data_r_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req_i) begin
            if (addr_ok) begin
              // Direction is carried by the next state, so wen needs no separate register.
              addr_q  <= data_add_i & ADDR_MASK;
              wdata_q <= data_wdata_i;
              be_q    <= data_be_i;
              if (data_wen_i) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                state   <= WR_REQ;
              end else begin
                arvalid <= 1'b1;
                state   <= RD_REQ;
              end
            end else begin
              data_r_valid_o <= 1'b1;
              data_r_rdata_o <= ERR_DATA;
              err_o          <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // Both channels done now or earlier (same-cycle completion included).
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready         <= 1'b0;
            data_r_valid_o <= 1'b1;
            data_r_rdata_o <= '0;
            if (bresp != 2'b00) err_o <= 1'b1;
            state          <= IDLE;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready         <= 1'b0;
            data_r_valid_o <= 1'b1;
            data_r_rdata_o <= rdata;
            if (rresp != 2'b00) err_o <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_mem_bridge.sv
// Testbench for axi_master_mem_bridge: directed accesses against a small AXI
// slave memory model with controllable ready timing and response codes.
module tb_axi_master_mem_bridge;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_DATA = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o;
  logic        data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        err_o;
  logic [0:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
  logic [9:0]  awuser, wuser, aruser;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [2:0]  dbg_state;

  // Slave model state and controls
  logic [31:0] mem [0:255];
  logic        aw_got, w_got, r_pend, r_hold;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  rresp_cfg;
  logic [31:0] last_awaddr, last_araddr;
  logic [7:0]  last_awlen, last_arlen;
  logic [2:0]  last_awsize;
  logic [1:0]  last_awburst;
  logic [3:0]  last_wstrb;
  logic        last_wlast;
  int          ar_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  axi_master_mem_bridge dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o), .err_o(err_o),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  assign bid   = 1'b0;
  assign rid   = 1'b0;
  assign rlast = 1'b1;

  // Slave: B answers the edge after both AW and W are in; R answers the edge after AR.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && awready) begin
        last_awaddr <= awaddr; last_awlen <= awlen;
        last_awsize <= awsize; last_awburst <= awburst;
      end
      if (wvalid && wready) begin
        last_wstrb <= wstrb; last_wlast <= wlast;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        for (int b = 0; b < 4; b++) begin
          if ((w_got ? s_wstrb[b] : wstrb[b]))
            mem[(aw_got ? s_awaddr[9:2] : awaddr[9:2])][b*8 +: 8] = w_got ? s_wdata[b*8 +: 8] : wdata[b*8 +: 8];
        end
        aw_got <= 1'b0; w_got <= 1'b0;
        bvalid <= 1'b1; bresp <= 2'b00;
      end else begin
        if (awvalid && awready) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
        if (wvalid && wready) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        last_araddr <= araddr; last_arlen <= arlen; ar_cnt <= ar_cnt + 1;
        if (r_hold) r_pend <= 1'b1;
        else begin
          rvalid <= 1'b1; rdata <= mem[araddr[9:2]]; rresp <= rresp_cfg;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Single access: request, wait for grant, then count cycles until completion.
  task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    int n;
    @(negedge clk);
    data_req_i = 1'b1; data_add_i = addr; data_wen_i = wen;
    data_wdata_i = wd; data_be_i = be;
    #1;
    n = 0;
    while (!data_gnt_o && n < 20) begin @(negedge clk); #1; n++; end
    if (!data_gnt_o) check("gnt_timeout", 32'(data_gnt_o), 32'd1);
    @(posedge clk); #1;
    data_req_i = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!data_r_valid_o && lat < 20);
    if (!data_r_valid_o) check("rvalid_timeout", 32'(data_r_valid_o), 32'd1);
    rd = data_r_rdata_o;
  endtask

  initial begin
    int lat, n, ar_before;
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h1111_0000;
    mem[1] = 32'h2222_0004;
    ar_cnt = 0;
    rst = 1'b1; data_req_i = 1'b0; data_add_i = '0; data_wen_i = 1'b0;
    data_wdata_i = '0; data_be_i = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    r_hold = 1'b0; rresp_cfg = 2'b00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_state",   32'(dbg_state), 32'(S_IDLE));
    check("rst_gnt",     32'(data_gnt_o), 32'd0);
    check("rst_valids",  32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
    check("rst_rvalid",  32'(data_r_valid_o), 32'd0);
    check("rst_rdata",   data_r_rdata_o, 32'd0);
    check("rst_err",     32'(err_o), 32'd0);
    rst = 1'b0;

    // 1: write with zero-wait slave
    access(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, lat, rd);
    check("t1_lat",    32'(lat), 32'd3);
    check("t1_awaddr", last_awaddr, 32'h10);
    check("t1_wstrb",  32'(last_wstrb), 32'hF);
    check("t1_wlast",  32'(last_wlast), 32'd1);
    check("t1_awattr", 32'({last_awlen, last_awsize, last_awburst}), 32'({8'd0, 3'd2, 2'b01}));
    check("t1_rdata0", rd, 32'd0);
    check("t1_mem",    mem[4], 32'hA5A5_5A5A);

    // 2: read back
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
    check("t2_lat",    32'(lat), 32'd3);
    check("t2_araddr", last_araddr, 32'h10);
    check("t2_arlen",  32'(last_arlen), 32'd0);
    check("t2_rdata",  rd, 32'hA5A5_5A5A);
    check("t2_err",    32'(err_o), 32'd0);

    // 3: awready late, wready immediate; unaligned address gets aligned
    awready = 1'b0;
    @(negedge clk);
    data_req_i = 1'b1; data_add_i = 32'h22; data_wen_i = 1'b1;
    data_wdata_i = 32'h1234_5678; data_be_i = 4'h3;
    #1 check("t3_gnt", 32'(data_gnt_o), 32'd1);
    @(posedge clk); #1 data_req_i = 1'b0;
    @(negedge clk);
    check("t3_c1_valids", 32'({awvalid, wvalid, bready}), 32'b110);
    @(negedge clk);
    check("t3_c2_valids", 32'({awvalid, wvalid, bready}), 32'b100);
    check("t3_c2_awaddr", awaddr, 32'h20);
    @(negedge clk);
    check("t3_c3_valids", 32'({awvalid, wvalid, bready}), 32'b100);
    awready = 1'b1;
    @(negedge clk);
    check("t3_c4_valids", 32'({awvalid, wvalid, bready}), 32'b001);
    @(negedge clk);
    check("t3_rvalid", 32'(data_r_valid_o), 32'd1);
    check("t3_awaddr", last_awaddr, 32'h20);
    access(1'b0, 32'h20, 32'h0, 4'h0, lat, rd);
    check("t3_strb_rd", rd, 32'h0000_5678);

    // 4: back-to-back reads with req held
    @(negedge clk);
    data_req_i = 1'b1; data_add_i = 32'h0; data_wen_i = 1'b0;
    #1 check("t4_gnt0", 32'(data_gnt_o), 32'd1);
    exp_q.push_back(32'h1111_0000);
    @(posedge clk); #1 data_add_i = 32'h4;
    @(negedge clk);
    check("t4_c1_gnt", 32'(data_gnt_o), 32'd0);
    @(negedge clk);
    check("t4_c2_rvalid", 32'(data_r_valid_o), 32'd0);
    @(negedge clk);
    check("t4_c3_rvalid", 32'(data_r_valid_o), 32'd1);
    check("t4_c3_gnt", 32'(data_gnt_o), 32'd1);
    check("t4_rd0", data_r_rdata_o, exp_q.pop_front());
    exp_q.push_back(32'h2222_0004);
    @(posedge clk); #1 data_req_i = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!data_r_valid_o && lat < 20);
    check("t4_lat1", 32'(lat), 32'd3);
    check("t4_rd1", data_r_rdata_o, exp_q.pop_front());

    // 5: SLVERR on read makes err_o sticky
    rresp_cfg = 2'b10;
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
    check("t5_err", 32'(err_o), 32'd1);
    rresp_cfg = 2'b00;
    access(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, lat, rd);
    access(1'b0, 32'h30, 32'h0, 4'h0, lat, rd);
    check("t5_rd_ok", rd, 32'hCAFE_F00D);
    check("t5_err_sticky", 32'(err_o), 32'd1);

    // 6: reset while waiting for read data
    r_hold = 1'b1;
    @(negedge clk);
    data_req_i = 1'b1; data_add_i = 32'h10; data_wen_i = 1'b0;
    @(posedge clk); #1 data_req_i = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (dbg_state != S_RD_DATA && n < 10);
    check("t6_in_rd_data", 32'(dbg_state), 32'(S_RD_DATA));
    rst = 1'b1;
    #1;
    check("t6_arvalid", 32'(arvalid), 32'd0);
    check("t6_rready",  32'(rready), 32'd0);
    check("t6_rvalid",  32'(data_r_valid_o), 32'd0);
    check("t6_state",   32'(dbg_state), 32'(S_IDLE));
    check("t6_err_clr", 32'(err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; r_hold = 1'b0;
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
    check("t6_after_rd", rd, 32'hA5A5_5A5A);

`ifdef MEM2AXI_ADDR_CHECK_EN
    // Out-of-window read answered locally
    ar_before = ar_cnt;
    @(negedge clk);
    data_req_i = 1'b1; data_add_i = 32'h500; data_wen_i = 1'b0;
    #1 check("oow_gnt", 32'(data_gnt_o), 32'd1);
    @(posedge clk); #1 data_req_i = 1'b0;
    check("oow_arvalid", 32'(arvalid), 32'd0);
    @(negedge clk);
    check("oow_rvalid", 32'(data_r_valid_o), 32'd1);
    check("oow_rdata",  data_r_rdata_o, 32'hDEAD_BEEF);
    check("oow_err",    32'(err_o), 32'd1);
    check("oow_no_ar",  32'(ar_cnt), 32'(ar_before));
`else
    ar_before = ar_cnt;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
